// File: rtl/mem_stream_out.sv
// Streams number_words consecutive memory words starting at base_address onto a
// valid/ready stream, using a small output FIFO and credit-limited read issue.
module mem_stream_out #(
  parameter int AW     = 9,
  parameter int DW     = 64,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_address,
  input  logic [AW-1:0] number_words,
  output logic [AW-1:0] read_address,
  output logic          read_en,
  input  logic [DW-1:0] read_data,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     issue_left;
  logic [AW-1:0]     out_left;
  logic [DW-1:0]     fifo_mem [DEPTH];
  logic [PW-1:0]     wr_idx;
  logic [PW-1:0]     rd_idx;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     inflight;
  logic [RD_LAT-1:0] ret_pipe;
  logic [CW:0]       occupancy;
  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fire_last;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (idx == PW'(DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  // A read is only issued when its word is guaranteed a FIFO slot on return,
  // counting both stored words and reads still travelling through memory.
  assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue     = (state == S_RUN) && (issue_left != '0) && (occupancy < (CW + 1)'(DEPTH));
  assign push      = ret_pipe[RD_LAT-1];
  assign m_valid   = (fifo_count != '0);
  assign pop       = m_valid && m_ready;
  assign m_last    = m_valid && (out_left == AW'(1));
  assign fire_last = pop && m_last;
  assign m_data    = m_valid ? fifo_mem[rd_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    read_en      = issue;
    read_address = rd_ptr;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (accept) state_next = (number_words == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (issue && (issue_left == AW'(1))) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (fire_last) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      issue_left <= '0;
      out_left   <= '0;
    end else if (accept) begin
      rd_ptr     <= base_address;
      issue_left <= number_words;
      out_left   <= number_words;
    end else begin
      if (issue) begin
        rd_ptr     <= rd_ptr + 1'b1;
        issue_left <= issue_left - 1'b1;
      end
      if (pop) out_left <= out_left - 1'b1;
    end
  end

  // Clearing the strobe pipe on reset is what discards returns from aborted reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_pipe <= '0;
      inflight <= '0;
    end else begin
      ret_pipe <= (ret_pipe << 1) | RD_LAT'(issue);
      inflight <= inflight + CW'(issue) - CW'(push);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_idx <= next_idx(wr_idx);
      if (pop)  rd_idx <= next_idx(rd_idx);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= read_data;
  end

endmodule

// File: tb/tb_mem_stream_out.sv
// Drives two mem_stream_out instances (RD_LAT=1 and RD_LAT=2) with identical
// stimulus and compares their streams against the expected memory sequence.
module tb_mem_stream_out;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] base_address;
  logic [8:0] number_words;
  logic       m_ready;

  logic [8:0]  read_address_s [2];
  logic        read_en_s      [2];
  logic [63:0] read_data_s    [2];
  logic [63:0] m_data_s       [2];
  logic        m_valid_s      [2];
  logic        m_last_s       [2];
  logic        busy_s         [2];
  logic        done_s         [2];

  logic [63:0] mem_img [512];

  int cyc = 0;
  int e0  = 0;
  int rel = 0;
  bit rec = 1'b0;
  int errors = 0;
  int checks = 0;

  int          n_iss     [2];
  logic [8:0]  iss_addr  [2][1024];
  int          iss_cyc   [2][1024];
  int          n_out     [2];
  logic [63:0] out_data  [2][1024];
  logic        out_last  [2][1024];
  int          out_cyc   [2][1024];
  int          n_valid   [2];
  int          done_cyc  [2];
  int          outs      [2];
  int          max_outs  [2];
  int          stall_err [2];
  int          flag_err  [2];
  bit          prev_stall[2];
  logic [63:0] prev_data [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [63:0] s1, s2;

    mem_stream_out #(.AW(9), .DW(64), .RD_LAT(g + 1), .DEPTH(4)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .base_address(base_address), .number_words(number_words),
      .read_address(read_address_s[g]), .read_en(read_en_s[g]),
      .read_data(read_data_s[g]),
      .m_data(m_data_s[g]), .m_valid(m_valid_s[g]), .m_ready(m_ready),
      .m_last(m_last_s[g]), .busy(busy_s[g]), .done(done_s[g])
    );

    always @(posedge clk) begin
      if (read_en_s[g]) s1 <= mem_img[read_address_s[g]];
      s2 <= s1;
    end

    if (g == 0) begin : g_l1
      assign read_data_s[g] = s1;
    end else begin : g_l2
      assign read_data_s[g] = s2;
    end
  end

  // Observes each cycle shortly after the falling edge, once inputs are settled.
  always @(negedge clk) begin
    #2;
    rel = cyc - e0 + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        outs[d]       = 0;
        prev_stall[d] = 1'b0;
      end else begin
        if (prev_stall[d] && (!m_valid_s[d] || m_data_s[d] !== prev_data[d])) stall_err[d]++;
        prev_stall[d] = m_valid_s[d] && !m_ready;
        prev_data[d]  = m_data_s[d];
        if (m_last_s[d] && !m_valid_s[d]) flag_err[d]++;
        if (done_s[d] && busy_s[d]) flag_err[d]++;
        outs[d] += int'(read_en_s[d]) - int'(m_valid_s[d] && m_ready);
        if (outs[d] > max_outs[d]) max_outs[d] = outs[d];
        if (rec && rel >= 1) begin
          if (read_en_s[d] && n_iss[d] < 1024) begin
            iss_addr[d][n_iss[d]] = read_address_s[d];
            iss_cyc[d][n_iss[d]]  = rel;
            n_iss[d]++;
          end
          if (m_valid_s[d]) n_valid[d]++;
          if (m_valid_s[d] && m_ready && n_out[d] < 1024) begin
            out_data[d][n_out[d]] = m_data_s[d];
            out_last[d][n_out[d]] = m_last_s[d];
            out_cyc[d][n_out[d]]  = rel;
            n_out[d]++;
          end
          if (done_s[d] && done_cyc[d] < 0) done_cyc[d] = rel;
        end
      end
    end
  end

  task automatic pulse_start(input logic [8:0] b, input logic [8:0] n);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_iss[d] = 0; n_out[d] = 0; n_valid[d] = 0; done_cyc[d] = -1;
      max_outs[d] = outs[d]; stall_err[d] = 0; flag_err[d] = 0;
    end
    base_address = b;
    number_words = n;
    start        = 1'b1;
    e0           = cyc + 1;
    rec          = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_until_done(input int mode, input int limit, input int mid_at,
                                output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (done_s[0] && done_s[1]) begin
        timed_out = 1'b0;
        break;
      end
      m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mid_at > 0 && i == mid_at) begin
        start        = 1'b1;
        base_address = base_address + 9'd200;
        number_words = 9'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    #3;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({read_address_s[d], read_en_s[d], m_valid_s[d], m_last_s[d], m_data_s[d], busy_s[d], done_s[d]} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs dut%0d: got addr=%0d re=%b v=%b last=%b data=%h busy=%b done=%b, want all zero",
                 d, read_address_s[d], read_en_s[d], m_valid_s[d], m_last_s[d], m_data_s[d], busy_s[d], done_s[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({m_valid_s[d], busy_s[d], done_s[d], read_en_s[d]} !== 4'b0) begin
        errors++;
        $display("[TB] FAIL idle_after_reset dut%0d: got v=%b busy=%b done=%b re=%b, want 0000",
                 d, m_valid_s[d], busy_s[d], done_s[d], read_en_s[d]);
      end
    end
  endtask

  task automatic test_basic;
    bit to;
    pulse_start(9'd0, 9'd8);
    run_until_done(0, 100, 0, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL basic_timeout: done not reached, want done"); end
    for (int d = 0; d < 2; d++) begin
      int lat = d + 1;
      checks++;
      if (n_iss[d] != 8 || n_out[d] != 8) begin
        errors++;
        $display("[TB] FAIL basic_counts dut%0d: got reads=%0d words=%0d, want 8/8", d, n_iss[d], n_out[d]);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (iss_cyc[d][i] != i + 1 || iss_addr[d][i] !== 9'(i)) begin
          errors++;
          $display("[TB] FAIL basic_read%0d dut%0d: got cycle=%0d addr=%0d, want cycle=%0d addr=%0d",
                   i, d, iss_cyc[d][i], iss_addr[d][i], i + 1, i);
        end
        checks++;
        if (out_cyc[d][i] != 2 + lat + i || out_data[d][i] !== mem_img[i] || out_last[d][i] !== (i == 7)) begin
          errors++;
          $display("[TB] FAIL basic_word%0d dut%0d: got cycle=%0d data=%h last=%b, want cycle=%0d data=%h last=%b",
                   i, d, out_cyc[d][i], out_data[d][i], out_last[d][i], 2 + lat + i, mem_img[i], i == 7);
        end
      end
      checks++;
      if (done_cyc[d] != 2 + lat + 8) begin
        errors++;
        $display("[TB] FAIL basic_done_cycle dut%0d: got %0d, want %0d", d, done_cyc[d], 2 + lat + 8);
      end
    end
  endtask

  task automatic test_stream(input string name, input logic [8:0] b, input int n, input int mode);
    bit to;
    pulse_start(b, 9'(n));
    run_until_done(mode, 4000, 0, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL %s_timeout: done not reached, want done", name); end
    for (int d = 0; d < 2; d++) begin
      int bad_data = 0;
      int bad_addr = 0;
      int lasts    = 0;
      for (int i = 0; i < n && i < 1024; i++) begin
        logic [8:0] a;
        a = 9'((int'(b) + i) % 512);
        if (iss_addr[d][i] !== a) bad_addr++;
        if (out_data[d][i] !== mem_img[a]) bad_data++;
        if (out_last[d][i] === 1'b1) lasts++;
      end
      checks++;
      if (n_out[d] != n || n_iss[d] != n) begin
        errors++;
        $display("[TB] FAIL %s_counts dut%0d: got reads=%0d words=%0d, want %0d", name, d, n_iss[d], n_out[d], n);
      end
      checks++;
      if (bad_addr != 0 || bad_data != 0) begin
        errors++;
        $display("[TB] FAIL %s_sequence dut%0d: got %0d bad addresses, %0d bad words, want 0/0", name, d, bad_addr, bad_data);
      end
      checks++;
      if (lasts != 1 || out_last[d][n-1] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s_last dut%0d: got %0d last flags, final=%b, want 1 on final", name, d, lasts, out_last[d][n-1]);
      end
      checks++;
      if (max_outs[d] > 4) begin
        errors++;
        $display("[TB] FAIL %s_occupancy dut%0d: got %0d outstanding, want <= 4", name, d, max_outs[d]);
      end
      checks++;
      if (stall_err[d] != 0 || flag_err[d] != 0) begin
        errors++;
        $display("[TB] FAIL %s_stability dut%0d: got %0d stall changes, %0d flag errors, want 0/0", name, d, stall_err[d], flag_err[d]);
      end
    end
  endtask

  task automatic test_zero_and_ignored_start;
    bit to;
    logic [8:0] b;
    pulse_start(9'd50, 9'd0);
    run_until_done(0, 20, 0, to);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (to || done_cyc[d] != 1 || n_iss[d] != 0 || n_valid[d] != 0) begin
        errors++;
        $display("[TB] FAIL zero_count dut%0d: got done_cycle=%0d reads=%0d valid=%0d, want 1/0/0",
                 d, done_cyc[d], n_iss[d], n_valid[d]);
      end
    end
    b = 9'($urandom_range(0, 511));
    pulse_start(b, 9'd16);
    run_until_done(1, 400, 4, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL ignored_start_timeout: done not reached, want done"); end
    for (int d = 0; d < 2; d++) begin
      int bad = 0;
      for (int i = 0; i < 16; i++)
        if (out_data[d][i] !== mem_img[9'((int'(b) + i) % 512)]) bad++;
      checks++;
      if (n_out[d] != 16 || n_iss[d] != 16 || bad != 0) begin
        errors++;
        $display("[TB] FAIL ignored_start dut%0d: got words=%0d reads=%0d bad=%0d, want 16/16/0", d, n_out[d], n_iss[d], bad);
      end
    end
  endtask

  task automatic test_reset_mid_transfer;
    bit to;
    bit reached = 1'b0;
    int vbad = 0;
    pulse_start(9'd300, 9'd32);
    m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (n_out[0] >= 5) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!reached) begin errors++; $display("[TB] FAIL reset_mid_progress: got %0d words, want >= 5", n_out[0]); end
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({read_address_s[d], read_en_s[d], m_valid_s[d], m_last_s[d], m_data_s[d], busy_s[d], done_s[d]} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_mid_outputs dut%0d: got addr=%0d re=%b v=%b last=%b data=%h busy=%b done=%b, want all zero",
                 d, read_address_s[d], read_en_s[d], m_valid_s[d], m_last_s[d], m_data_s[d], busy_s[d], done_s[d]);
      end
    end
    @(negedge clk);
    rst     = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) if (m_valid_s[d] || busy_s[d]) vbad++;
    end
    checks++;
    if (vbad != 0) begin errors++; $display("[TB] FAIL reset_stale_word: got %0d active cycles, want 0", vbad); end
    pulse_start(9'd100, 9'd4);
    run_until_done(0, 100, 0, to);
    for (int d = 0; d < 2; d++) begin
      int bad = 0;
      for (int i = 0; i < 4; i++) if (out_data[d][i] !== mem_img[100 + i]) bad++;
      checks++;
      if (to || n_out[d] != 4 || bad != 0) begin
        errors++;
        $display("[TB] FAIL reset_followup dut%0d: got words=%0d bad=%0d, want 4/0", d, n_out[d], bad);
      end
    end
  endtask

  task automatic test_full_size;
    test_stream("full", 9'd1, 511, 1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (iss_addr[d][510] !== 9'd511 || out_data[d][510] !== mem_img[511]) begin
        errors++;
        $display("[TB] FAIL full_last_address dut%0d: got addr=%0d data=%h, want addr=511 data=%h",
                 d, iss_addr[d][510], out_data[d][510], mem_img[511]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; m_ready = 1'b0;
    base_address = '0; number_words = '0;
    for (int d = 0; d < 2; d++) begin
      outs[d] = 0; prev_stall[d] = 1'b0; prev_data[d] = '0;
      n_iss[d] = 0; n_out[d] = 0; n_valid[d] = 0; done_cyc[d] = -1;
      max_outs[d] = 0; stall_err[d] = 0; flag_err[d] = 0;
    end
    for (int i = 0; i < 512; i++) mem_img[i] = {$urandom(), $urandom()};
    test_reset();
    test_basic();
    test_stream("backpressure", 9'($urandom_range(0, 511)), 64, 1);
    test_stream("wrap", 9'd508, 6, 1);
    test_zero_and_ignored_start();
    test_reset_mid_transfer();
    test_full_size();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
